// File: rtl/iir_mem_arbiter_if.sv
// Signal bundle between the IIR filter, the host port, the arbiter and the sample SRAM.
// The arbiter uses the slave view; the surrounding system (filter, host, SRAM) uses master.
interface iir_mem_arbiter_if #(
   parameter int N = 16,
   parameter int M = 20
);
   logic                f_rd;
   logic [M-1:0]        f_raddr;
   logic                f_wr;
   logic [M-1:0]        f_waddr;
   logic signed [N-1:0] f_wdata;
   logic                f_stall;
   logic signed [N-1:0] f_rdata;
   logic                f_rvalid;

   logic                h_req;
   logic                h_we;
   logic [M-1:0]        h_addr;
   logic [N-1:0]        h_wdata;
   logic                h_gnt;
   logic [N-1:0]        h_rdata;
   logic                h_rvalid;

   logic                mem_ce;
   logic                mem_we;
   logic [M-1:0]        mem_addr;
   logic [N-1:0]        mem_wdata;
   logic [N-1:0]        mem_rdata;

   modport master (
      output f_rd, f_raddr, f_wr, f_waddr, f_wdata,
      input  f_stall, f_rdata, f_rvalid,
      output h_req, h_we, h_addr, h_wdata,
      input  h_gnt, h_rdata, h_rvalid,
      input  mem_ce, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  f_rd, f_raddr, f_wr, f_waddr, f_wdata,
      output f_stall, f_rdata, f_rvalid,
      input  h_req, h_we, h_addr, h_wdata,
      output h_gnt, h_rdata, h_rvalid,
      output mem_ce, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/iir_mem_arbiter.sv
// Single-port sample SRAM arbiter between an IIR filter datapath and a host port.
// Filter normally wins; a starve counter hands one slot to the host after STARVE_MAX filter grants.
module iir_mem_arbiter #(
   parameter int N          = 16,
   parameter int M          = 20,
   parameter int STARVE_MAX = 8
) (
   input logic               clk,
   input logic               rst,
   iir_mem_arbiter_if.slave  bus
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [0:0] FILT = 1'b0;
   localparam logic [0:0] HOST = 1'b1;

   logic [0:0]          r_state;
   logic [SW-1:0]       r_starve;
   logic                r_wr_done;
   logic                r_mem_ce;
   logic                r_mem_we;
   logic [M-1:0]        r_mem_addr;
   logic signed [N-1:0] r_mem_wdata;
   logic                r_vld_p0;
   logic                r_host_p0;
   logic                r_vld_p1;
   logic                r_host_p1;
   logic signed [N-1:0] r_f_rdata;
   logic [N-1:0]        r_h_rdata;

   logic                w_f_wr;
   logic                w_acc_fw;
   logic                w_acc_fr;
   logic                w_acc_h;
   logic                w_f_acc;
   logic                w_any_acc;
   logic                w_cmd_we;
   logic                w_cmd_rd;
   logic [M-1:0]        w_cmd_addr;
   logic signed [N-1:0] w_cmd_wdata;
   logic [SW-1:0]       w_starve_nxt;
   logic [0:0]          w_state_nxt;
   logic                w_f_strobe;
   logic                w_h_strobe;

   // Once the write half of a simultaneous write+read is done, only the read is still owed.
   assign w_f_wr = bus.f_wr & ~r_wr_done;

   always_comb begin
      w_acc_fw = 1'b0;
      w_acc_fr = 1'b0;
      w_acc_h  = 1'b0;
      if (r_state == HOST && bus.h_req) w_acc_h = 1'b1;
      else if (w_f_wr)                  w_acc_fw = 1'b1;
      else if (bus.f_rd)                w_acc_fr = 1'b1;
      else if (bus.h_req)               w_acc_h = 1'b1;
   end

   assign w_f_acc     = w_acc_fw | w_acc_fr;
   assign w_any_acc   = w_f_acc | w_acc_h;
   assign w_cmd_we    = w_acc_fw | (w_acc_h & bus.h_we);
   assign w_cmd_rd    = w_acc_fr | (w_acc_h & ~bus.h_we);
   assign w_cmd_addr  = w_acc_h ? bus.h_addr : (w_acc_fw ? bus.f_waddr : bus.f_raddr);
   assign w_cmd_wdata = w_acc_h ? $signed(bus.h_wdata) : bus.f_wdata;

   // The filter sees a stall until its whole pending request (both halves of a pair) is taken.
   assign bus.f_stall = (bus.f_rd | bus.f_wr) & ~(w_acc_fr | (w_acc_fw & ~bus.f_rd));
   assign bus.h_gnt   = w_acc_h;

   always_comb begin
      w_starve_nxt = r_starve;
      if (w_acc_h || !bus.h_req)               w_starve_nxt = '0;
      else if (w_f_acc && r_starve != STARVE_LIM) w_starve_nxt = r_starve + 1'b1;

      w_state_nxt = r_state;
      if (r_state == FILT && w_starve_nxt == STARVE_LIM) w_state_nxt = HOST;
      else if (r_state == HOST && w_acc_h)              w_state_nxt = FILT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= FILT;
         r_starve  <= '0;
         r_wr_done <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_starve <= w_starve_nxt;
         if (w_acc_fw && bus.f_rd)        r_wr_done <= 1'b1;
         else if (w_acc_fr || !bus.f_rd)  r_wr_done <= 1'b0;
      end
   end

   // Command stage: registered SRAM command plus read tag (p0), data stage tag (p1).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_ce    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_vld_p0    <= 1'b0;
         r_host_p0   <= 1'b0;
         r_vld_p1    <= 1'b0;
         r_host_p1   <= 1'b0;
      end else begin
         r_mem_ce  <= w_any_acc;
         r_mem_we  <= w_cmd_we;
         if (w_any_acc) r_mem_addr  <= w_cmd_addr;
         if (w_cmd_we)  r_mem_wdata <= w_cmd_wdata;
         r_vld_p0  <= w_cmd_rd;
         r_host_p0 <= w_acc_h;
         r_vld_p1  <= r_vld_p0;
         r_host_p1 <= r_host_p0;
      end
   end

   assign w_f_strobe = r_vld_p1 & ~r_host_p1;
   assign w_h_strobe = r_vld_p1 & r_host_p1;

   // Data stage: SRAM data is forwarded during the strobe and held afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_f_rdata <= '0;
         r_h_rdata <= '0;
      end else begin
         if (w_f_strobe) r_f_rdata <= $signed(bus.mem_rdata);
         if (w_h_strobe) r_h_rdata <= bus.mem_rdata;
      end
   end

   assign bus.mem_ce    = r_mem_ce;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.f_rvalid  = w_f_strobe;
   assign bus.h_rvalid  = w_h_strobe;
   assign bus.f_rdata   = w_f_strobe ? $signed(bus.mem_rdata) : r_f_rdata;
   assign bus.h_rdata   = w_h_strobe ? bus.mem_rdata : r_h_rdata;
endmodule

// File: tb/tb_iir_mem_arbiter.sv
// Bench for iir_mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (priority rules, shadow memory, expected-response queue).
module tb_iir_mem_arbiter;
   localparam int N    = 16;
   localparam int M    = 20;
   localparam int SMAX = 8;

   typedef struct {
      bit           host;
      logic [N-1:0] data;
      int           due;
   } rsp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   logic [N-1:0]  sram [0:1023];
   logic [1023:0] sram_wr;
   logic [N-1:0]  shadow [logic [M-1:0]];
   rsp_t          q [$];

   iir_mem_arbiter_if #(.N(N), .M(M)) bus ();
   iir_mem_arbiter #(.N(N), .M(M), .STARVE_MAX(SMAX)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [N-1:0] dflt(input logic [M-1:0] a);
      return N'((a * 20'h09E37) ^ 20'h05A5A);
   endfunction

   function automatic logic [N-1:0] rd_shadow(input logic [M-1:0] a);
      return shadow.exists(a) ? shadow[a] : dflt(a);
   endfunction

   // Registered single-port SRAM: read data appears the cycle after mem_ce.
   always @(posedge clk) begin
      if (rst) sram_wr <= '0;
      else if (bus.mem_ce) begin
         if (bus.mem_we) begin
            sram[bus.mem_addr[9:0]]    <= bus.mem_wdata;
            sram_wr[bus.mem_addr[9:0]] <= 1'b1;
         end else begin
            bus.mem_rdata <= sram_wr[bus.mem_addr[9:0]] ? sram[bus.mem_addr[9:0]] : dflt(bus.mem_addr);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_in();
      bus.f_rd = 1'b0; bus.f_raddr = '0; bus.f_wr = 1'b0; bus.f_waddr = '0; bus.f_wdata = '0;
      bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_in();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_in();
      tick();
      tick();
      n_vec++; if ({bus.mem_ce, bus.mem_we, bus.f_rvalid, bus.h_rvalid} !== 4'b0000) begin n_err++; $display("FAIL rst_ctrl: got ce/we/fv/hv=%b want 0000", {bus.mem_ce, bus.mem_we, bus.f_rvalid, bus.h_rvalid}); end
      n_vec++; if (bus.mem_addr !== '0) begin n_err++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
      n_vec++; if (bus.mem_wdata !== '0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
      n_vec++; if ({bus.f_rdata, bus.h_rdata} !== '0) begin n_err++; $display("FAIL rst_rdata: got f=%h h=%h want 0", bus.f_rdata, bus.h_rdata); end
      bus.h_req = 1'b1;
      #1;
      n_vec++; if (bus.h_gnt !== 1'b1 || bus.f_stall !== 1'b0) begin n_err++; $display("FAIL rst_hgnt: got gnt=%b stall=%b want 1/0", bus.h_gnt, bus.f_stall); end
      bus.f_rd = 1'b1;
      #1;
      n_vec++; if (bus.h_gnt !== 1'b0 || bus.f_stall !== 1'b0) begin n_err++; $display("FAIL rst_fprio: got gnt=%b stall=%b want 0/0", bus.h_gnt, bus.f_stall); end
      idle_in();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_idle();
      int bad;
      bad = 0;
      idle_in();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         n_vec++; if (bus.mem_ce !== 1'b0 || bus.f_rvalid !== 1'b0 || bus.h_rvalid !== 1'b0 || bus.h_gnt !== 1'b0) begin n_err++; bad++; $display("FAIL idle_%0d: got ce=%b fv=%b hv=%b gnt=%b want 0", k, bus.mem_ce, bus.f_rvalid, bus.h_rvalid, bus.h_gnt); end
         tick();
      end
   endtask

   task automatic test_filter_read();
      bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = M'(5); bus.h_wdata = 16'h1234;
      @(negedge clk);
      n_vec++; if (bus.h_gnt !== 1'b1) begin n_err++; $display("FAIL hw5_gnt: got %b want 1", bus.h_gnt); end
      tick();
      idle_in();
      n_vec++; if (bus.mem_ce !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== M'(5) || bus.mem_wdata !== 16'h1234) begin n_err++; $display("FAIL hw5_cmd: got ce=%b we=%b a=%h d=%h want 1/1/5/1234", bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      tick();
      bus.f_rd = 1'b1; bus.f_raddr = M'(5);
      @(negedge clk);
      n_vec++; if (bus.f_stall !== 1'b0) begin n_err++; $display("FAIL frd_stall0: got %b want 0", bus.f_stall); end
      tick();
      bus.f_rd = 1'b0;
      @(negedge clk);
      n_vec++; if (bus.mem_ce !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== M'(5) || bus.f_rvalid !== 1'b0 || bus.f_stall !== 1'b0) begin n_err++; $display("FAIL frd_cmd: got ce=%b we=%b a=%h fv=%b st=%b want 1/0/5/0/0", bus.mem_ce, bus.mem_we, bus.mem_addr, bus.f_rvalid, bus.f_stall); end
      tick();
      @(negedge clk);
      n_vec++; if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== 16'h1234 || bus.h_rvalid !== 1'b0) begin n_err++; $display("FAIL frd_data: got fv=%b d=%h hv=%b want 1/1234/0", bus.f_rvalid, bus.f_rdata, bus.h_rvalid); end
      tick();
      @(negedge clk);
      n_vec++; if (bus.f_rvalid !== 1'b0 || bus.f_rdata !== 16'h1234 || bus.mem_ce !== 1'b0) begin n_err++; $display("FAIL frd_hold: got fv=%b d=%h ce=%b want 0/1234/0", bus.f_rvalid, bus.f_rdata, bus.mem_ce); end
      tick();
   endtask

   task automatic test_rw_pair();
      bus.f_wr = 1'b1; bus.f_waddr = M'(3); bus.f_wdata = 16'h0ABC;
      bus.f_rd = 1'b1; bus.f_raddr = M'(7);
      @(negedge clk);
      n_vec++; if (bus.f_stall !== 1'b1) begin n_err++; $display("FAIL pair_stall1: got %b want 1", bus.f_stall); end
      tick();
      @(negedge clk);
      n_vec++; if (bus.mem_ce !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== M'(3) || bus.mem_wdata !== 16'h0ABC) begin n_err++; $display("FAIL pair_wcmd: got ce=%b we=%b a=%h d=%h want 1/1/3/0abc", bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      n_vec++; if (bus.f_stall !== 1'b0) begin n_err++; $display("FAIL pair_stall2: got %b want 0", bus.f_stall); end
      tick();
      idle_in();
      @(negedge clk);
      n_vec++; if (bus.mem_ce !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== M'(7)) begin n_err++; $display("FAIL pair_rcmd: got ce=%b we=%b a=%h want 1/0/7", bus.mem_ce, bus.mem_we, bus.mem_addr); end
      tick();
      @(negedge clk);
      n_vec++; if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== dflt(M'(7))) begin n_err++; $display("FAIL pair_rdata: got fv=%b d=%h want 1/%h", bus.f_rvalid, bus.f_rdata, dflt(M'(7))); end
      bus.f_rd = 1'b1; bus.f_raddr = M'(3);
      tick();
      bus.f_rd = 1'b0;
      tick();
      @(negedge clk);
      n_vec++; if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== 16'h0ABC) begin n_err++; $display("FAIL pair_raw: got fv=%b d=%h want 1/0abc", bus.f_rvalid, bus.f_rdata); end
      tick();
   endtask

   task automatic test_starve();
      int acc;
      bit got;
      acc = 0;
      got = 1'b0;
      bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = M'(32'h20);
      bus.f_rd = 1'b1; bus.f_raddr = M'(32'h40);
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (bus.h_gnt === 1'b1) begin
            got = 1'b1;
            n_vec++; if (acc != SMAX) begin n_err++; $display("FAIL starve_cnt: got %0d filter accepts want %0d", acc, SMAX); end
            n_vec++; if (bus.f_stall !== 1'b1) begin n_err++; $display("FAIL starve_fstall: got %b want 1", bus.f_stall); end
         end else if (bus.f_stall === 1'b0) acc++;
         tick();
         bus.f_raddr = bus.f_raddr + 1'b1;
      end
      n_vec++; if (!got) begin n_err++; $display("FAIL starve_timeout: got no h_gnt in 40 cycles want gnt"); end
      @(negedge clk);
      n_vec++; if (bus.h_gnt !== 1'b0 || bus.f_stall !== 1'b0) begin n_err++; $display("FAIL starve_back: got gnt=%b stall=%b want 0/0", bus.h_gnt, bus.f_stall); end
      tick();
      idle_in();
      repeat (4) tick();
   endtask

   task automatic test_host_write_filter_read();
      bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = M'(32'h10); bus.h_wdata = 16'hBEEF;
      @(negedge clk);
      n_vec++; if (bus.h_gnt !== 1'b1) begin n_err++; $display("FAIL hwfr_gnt: got %b want 1", bus.h_gnt); end
      tick();
      idle_in();
      bus.f_rd = 1'b1; bus.f_raddr = M'(32'h10);
      @(negedge clk);
      n_vec++; if (bus.mem_ce !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== M'(32'h10) || bus.mem_wdata !== 16'hBEEF) begin n_err++; $display("FAIL hwfr_wcmd: got ce=%b we=%b a=%h d=%h want 1/1/10/beef", bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      tick();
      bus.f_rd = 1'b0;
      tick();
      @(negedge clk);
      n_vec++; if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== 16'hBEEF || bus.h_rvalid !== 1'b0) begin n_err++; $display("FAIL hwfr_data: got fv=%b d=%h hv=%b want 1/beef/0", bus.f_rvalid, bus.f_rdata, bus.h_rvalid); end
      tick();
   endtask

   task automatic test_reset_mid_read();
      int pulses;
      pulses = 0;
      bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = M'(32'h10);
      @(negedge clk);
      n_vec++; if (bus.h_gnt !== 1'b1) begin n_err++; $display("FAIL rmr_gnt: got %b want 1", bus.h_gnt); end
      tick();
      idle_in();
      n_vec++; if (bus.mem_ce !== 1'b1) begin n_err++; $display("FAIL rmr_ce: got %b want 1", bus.mem_ce); end
      rst = 1'b1;
      #1;
      n_vec++; if ({bus.mem_ce, bus.mem_we, bus.f_rvalid, bus.h_rvalid} !== 4'b0000 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin n_err++; $display("FAIL rmr_zero: got ce/we/fv/hv=%b a=%h d=%h want 0", {bus.mem_ce, bus.mem_we, bus.f_rvalid, bus.h_rvalid}, bus.mem_addr, bus.mem_wdata); end
      n_vec++; if ({bus.f_rdata, bus.h_rdata} !== '0) begin n_err++; $display("FAIL rmr_rdata: got f=%h h=%h want 0", bus.f_rdata, bus.h_rdata); end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.h_rvalid === 1'b1) pulses++;
         tick();
      end
      n_vec++; if (pulses != 0) begin n_err++; $display("FAIL rmr_nopulse: got %0d h_rvalid pulses want 0", pulses); end
   endtask

   task automatic test_random();
      bit fr, fw, hr, hwe;
      logic [M-1:0] fra, fwa, ha;
      logic [N-1:0] fwd, hwd, got_d;
      bit exp_ce, exp_we, e_stall, e_fv, e_hv, host_turn, wr_done;
      logic [M-1:0] exp_addr;
      logic [N-1:0] exp_wdata;
      int waits, win, k;
      fr = 0; fw = 0; hr = 0; hwe = 0;
      fra = '0; fwa = '0; ha = '0; fwd = '0; hwd = '0;
      exp_ce = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
      host_turn = 0; wr_done = 0; waits = 0;
      shadow.delete();
      q.delete();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (i < 590) begin
            if (!fr && !fw) begin
               k = int'($urandom_range(0, 5));
               fr = (k == 1 || k == 2 || k == 4);
               fw = (k == 3 || k == 4);
               fra = M'(32'h100 + $urandom_range(0, 15));
               fwa = M'(32'h100 + $urandom_range(0, 15));
               fwd = N'($urandom);
            end
            if (!hr) begin
               if ($urandom_range(0, 9) < 3) begin
                  hr = 1; hwe = 1'($urandom_range(0, 1));
                  ha = M'(32'h100 + $urandom_range(0, 15)); hwd = N'($urandom);
               end
            end else if ($urandom_range(0, 19) == 0) hr = 0;
         end else hr = 0;
         bus.f_rd = fr; bus.f_raddr = fra; bus.f_wr = fw; bus.f_waddr = fwa; bus.f_wdata = fwd;
         bus.h_req = hr; bus.h_we = hwe; bus.h_addr = ha; bus.h_wdata = hwd;

         if (host_turn && hr)   win = 3;
         else if (fw && !wr_done) win = 1;
         else if (fr)           win = 2;
         else if (hr)           win = 3;
         else                   win = 0;
         e_stall = (fr || fw) && !(win == 2 || (win == 1 && !fr));

         while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
         e_fv = (q.size() > 0 && q[0].due == cyc && !q[0].host);
         e_hv = (q.size() > 0 && q[0].due == cyc && q[0].host);

         @(negedge clk);
         n_vec++; if (bus.f_stall !== e_stall) begin n_err++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, bus.f_stall, e_stall); end
         n_vec++; if (bus.h_gnt !== (win == 3)) begin n_err++; $display("FAIL rnd_gnt c%0d: got %b want %b", cyc, bus.h_gnt, (win == 3)); end
         n_vec++; if (bus.mem_ce !== exp_ce) begin n_err++; $display("FAIL rnd_ce c%0d: got %b want %b", cyc, bus.mem_ce, exp_ce); end
         if (exp_ce) begin
            n_vec++; if (bus.mem_we !== exp_we || bus.mem_addr !== exp_addr || (exp_we && bus.mem_wdata !== exp_wdata)) begin n_err++; $display("FAIL rnd_cmd c%0d: got we=%b a=%h d=%h want %b/%h/%h", cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_we, exp_addr, exp_wdata); end
         end
         n_vec++; if (bus.f_rvalid !== e_fv || bus.h_rvalid !== e_hv) begin n_err++; $display("FAIL rnd_vld c%0d: got fv=%b hv=%b want %b/%b", cyc, bus.f_rvalid, bus.h_rvalid, e_fv, e_hv); end
         if (e_fv || e_hv) begin
            got_d = e_fv ? bus.f_rdata : bus.h_rdata;
            n_vec++; if (got_d !== q[0].data) begin n_err++; $display("FAIL rnd_data c%0d: got %h want %h", cyc, got_d, q[0].data); end
            void'(q.pop_front());
         end

         exp_ce = (win != 0);
         exp_we = (win == 1) || (win == 3 && hwe);
         case (win)
            1: begin exp_addr = fwa; exp_wdata = fwd; shadow[fwa] = fwd; end
            2: begin exp_addr = fra; q.push_back('{host: 1'b0, data: rd_shadow(fra), due: cyc + 2}); end
            3: begin
               exp_addr = ha;
               if (hwe) begin exp_wdata = hwd; shadow[ha] = hwd; end
               else q.push_back('{host: 1'b1, data: rd_shadow(ha), due: cyc + 2});
            end
            default: ;
         endcase

         if (win == 3) begin waits = 0; host_turn = 0; end
         else if (!hr) waits = 0;
         else if (win == 1 || win == 2) begin
            waits++;
            if (waits == SMAX) host_turn = 1;
         end
         if (win == 1 && fr) wr_done = 1;
         else if (win == 2 || !fr) wr_done = 0;

         if (win == 1 && !fr) fw = 0;
         if (win == 2) begin fr = 0; fw = 0; end
         if (win == 3) hr = 0;
         tick();
      end
      n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_drain: got %0d reads outstanding want 0", q.size()); end
      idle_in();
   endtask

   initial begin
      test_reset();
      test_idle();
      test_filter_read();
      test_rw_pair();
      test_starve();
      test_host_write_filter_read();
      test_reset_mid_read();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/iir_mem_arbiter.md
IIR_MEM_ARBITER -- requirements
Module: iir_mem_arbiter

Interface
REQ-001 Parameter N, default 16, sample data width.
REQ-002 Parameter M, default 20, sample memory address width.
REQ-003 Parameter STARVE_MAX, default 8, max consecutive filter grants while host waits.
REQ-004 clk  input  1  single clock; all flops on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 f_rd  input  1  filter read request (load).
REQ-007 f_raddr  input  M  filter read address.
REQ-008 f_wr  input  1  filter write request (WEN).
REQ-009 f_waddr  input  M  filter write address.
REQ-010 f_wdata  input  N  filter write data (Yn), signed.
REQ-011 f_stall  output  1  filter request not accepted this cycle.
REQ-012 f_rdata  output  N  read data returned to filter (DIn).
REQ-013 f_rvalid  output  1  f_rdata valid strobe.
REQ-014 h_req  input  1  host access request, held until h_gnt.
REQ-015 h_we  input  1  host write (1) / read (0).
REQ-016 h_addr  input  M  host address.
REQ-017 h_wdata  input  N  host write data.
REQ-018 h_gnt  output  1  host request accepted this cycle.
REQ-019 h_rdata  output  N  host read data.
REQ-020 h_rvalid  output  1  h_rdata valid strobe.
REQ-021 mem_ce / mem_we  output  1 each  registered single-port SRAM enable/write.
REQ-022 mem_addr  output  M; mem_wdata  output  N  registered SRAM address/data.
REQ-023 mem_rdata  input  N  SRAM read data, valid one cycle after mem_ce with mem_we=0.

Function
REQ-024 Accept decision combinational per cycle; at most one request accepted per cycle.
REQ-025 Owner FSM states: FILT (filter priority) and HOST (host priority); reset state FILT.
REQ-026 FILT: priority f_wr > f_rd > h_req.
REQ-027 HOST: priority h_req > f_wr > f_rd; FSM returns to FILT the cycle after h_gnt.
REQ-028 Starve counter (width ceil(log2(STARVE_MAX+1))): increments on each filter accept while h_req=1; clears on h_gnt or h_req=0; FILT->HOST when counter reaches STARVE_MAX.
REQ-029 f_stall = (f_rd|f_wr) and no filter request accepted this cycle; filter holds request and address while f_stall=1.
REQ-030 f_rd and f_wr both high: write accepted first; read accepted no earlier than next cycle, f_stall=1 meanwhile.
REQ-031 Accepted request drives mem_ce=1, mem_we, mem_addr, mem_wdata on next clock edge (1-cycle command latency); no accept -> mem_ce=0, mem_we=0, addr/data hold.
REQ-032 Read tag pipeline (2 stages: command, data) routes mem_rdata to f_rdata with f_rvalid, or h_rdata with h_rvalid, exactly 2 cycles after acceptance; rdata registers hold between strobes.
REQ-033 Write has no response strobe; write to an address followed by a read of it returns written data (SRAM order preserved, no reordering).
REQ-034 h_gnt is one-cycle pulse per accepted host request; host deasserting h_req before h_gnt cancels it silently.
REQ-035 Addresses pass unmodified, no wrap or range check.

Reset
REQ-036 rst=1 immediately forces: FSM=FILT, starve counter=0, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0, f_rvalid=0, h_rvalid=0, f_rdata=0, h_rdata=0, tag pipeline cleared.
REQ-037 Reset mid-read discards in-flight read: no rvalid strobe after rst release.
REQ-038 f_stall and h_gnt during rst reflect combinational rules with FSM=FILT and are ignored by requesters.

Verification
REQ-039 Filter read only, f_raddr=5, mem holds 0x1234 -> cycle+1 mem_ce=1/addr=5, cycle+2 f_rvalid=1, f_rdata=0x1234, f_stall=0 throughout.
REQ-040 f_rd and f_wr both high (waddr=3, raddr=7) -> write to 3 issued first, f_stall=1 one cycle, then read of 7.
REQ-041 Filter requests every cycle, h_req held -> h_gnt after exactly STARVE_MAX=8 filter accepts; filter stalled that cycle; FSM back to FILT next cycle.
REQ-042 Host write addr 0x10 data 0xBEEF then filter read 0x10 -> f_rdata=0xBEEF.
REQ-043 rst asserted one cycle after host read accepted -> h_rvalid never pulses; all outputs 0 immediately.
REQ-044 Idle (no requests) 20 cycles -> mem_ce=0, no strobes, starve counter stays 0.
